imem_port_arbiter: RTL and testbench



---
 rtl/imem_port_arbiter.sv | 105 ++++++++++
 tb/tb_imem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the instruction memory read port between fetch and debug requesters; `IMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed fetch priority.
// Latency: accept in cycle N, registered response valid in N+1; a held response blocks new grants until it handshakes.
module imem_port_arbiter #(
  parameter int          MEMORY_SIZE = 1024,
  parameter logic [31:0] ERR_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req_valid,
  input  logic [31:0] f_req_addr,
  output logic        f_req_ready,
  output logic        f_resp_valid,
  output logic [31:0] f_resp_data,
  output logic        f_resp_err,
  input  logic        f_resp_ready,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  input  logic        d_resp_ready,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_instruction_in
);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEMORY_SIZE);

  state_t      state;
  logic        grant_f;
  logic        grant_d;
  logic        resp_hs;
  logic        port_free;
  logic        accept_f;
  logic        accept_d;
  logic        addr_err;
  logic [31:0] sel_addr;
  logic [31:0] load_word;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic last_f;

  // On contention the requester that did not win the previous acceptance goes first.
  always_comb begin
    grant_f = f_req_valid && (!d_req_valid || !last_f);
    grant_d = d_req_valid && !grant_f;
  end
`else
  always_comb begin
    grant_f = f_req_valid;
    grant_d = d_req_valid && !f_req_valid;
  end
`endif

  assign resp_hs   = (state == BUSY_F && f_resp_ready) || (state == BUSY_D && d_resp_ready);
  assign port_free = (state == IDLE) || resp_hs;
  assign accept_f  = grant_f && port_free && !reset;
  assign accept_d  = grant_d && port_free && !reset;

  assign f_req_ready = accept_f;
  assign d_req_ready = accept_d;

  assign sel_addr         = grant_f ? f_req_addr : (grant_d ? d_req_addr : 32'h0);
  assign mem_read_address = sel_addr;
  assign addr_err         = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_LIMIT);
  assign load_word        = addr_err ? ERR_WORD : mem_instruction_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      f_resp_valid <= 1'b0;
      f_resp_data  <= 32'h0;
      f_resp_err   <= 1'b0;
      d_resp_valid <= 1'b0;
      d_resp_data  <= 32'h0;
      d_resp_err   <= 1'b0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      last_f       <= 1'b0;
`endif
    end else if (accept_f || accept_d) begin
      // Non-owner response fields are forced to zero so only the owner sees data.
      state        <= accept_f ? BUSY_F : BUSY_D;
      f_resp_valid <= accept_f;
      f_resp_data  <= accept_f ? load_word : 32'h0;
      f_resp_err   <= accept_f && addr_err;
      d_resp_valid <= accept_d;
      d_resp_data  <= accept_d ? load_word : 32'h0;
      d_resp_err   <= accept_d && addr_err;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      last_f       <= accept_f;
`endif
    end else if (resp_hs) begin
      state        <= IDLE;
      f_resp_valid <= 1'b0;
      f_resp_data  <= 32'h0;
      f_resp_err   <= 1'b0;
      d_resp_valid <= 1'b0;
      d_resp_data  <= 32'h0;
      d_resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized scoreboard bench for imem_port_arbiter: a transaction-level model predicts grants and queues expected responses.
module tb_imem_port_arbiter;

  localparam logic [31:0] ERR_WORD = 32'h00000013;
  localparam int          MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req_valid, f_req_ready, f_resp_valid, f_resp_err, f_resp_ready;
  logic [31:0] f_req_addr, f_resp_data;
  logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_err, d_resp_ready;
  logic [31:0] d_req_addr, d_resp_data;
  logic [31:0] mem_read_address, mem_instruction_in;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  started = 0;
  bit  last_was_f = 0;

  bit          f_want, d_want;
  logic [31:0] f_a, d_a;
  bit          acc_f, acc_d;

  imem_port_arbiter #(.MEMORY_SIZE(MEM_SIZE), .ERR_WORD(ERR_WORD)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data), .f_resp_err(f_resp_err),
    .f_resp_ready(f_resp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .d_resp_ready(d_resp_ready),
    .mem_read_address(mem_read_address), .mem_instruction_in(mem_instruction_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb mem_instruction_in = mem[mem_read_address[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t expect_word(input logic [31:0] addr);
    exp_t e;
    e.err  = (addr % 4 != 0) || (addr >= MEM_SIZE);
    e.data = e.err ? ERR_WORD : mem[addr / 4];
    e.cyc  = cyc;
    return e;
  endfunction

  // Called just after a falling edge with requester state set; checks request side and queues expectations.
  task automatic drive_cycle();
    bit free, win_f, win_d;
    logic [31:0] exp_addr;
    f_req_valid = f_want;
    f_req_addr  = f_a;
    d_req_valid = d_want;
    d_req_addr  = d_a;
    #1;
    free = (fq.size() == 0 && dq.size() == 0) || (fq.size() > 0 && f_resp_ready)
           || (dq.size() > 0 && d_resp_ready);
    win_f = 0;
    win_d = 0;
    if (f_want && d_want) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      win_f = !last_was_f;
      win_d = last_was_f;
`else
      win_f = 1;
`endif
    end else begin
      win_f = f_want;
      win_d = d_want;
    end
    exp_addr = win_f ? f_a : (win_d ? d_a : 32'h0);
    acc_f = win_f && free && !reset;
    acc_d = win_d && free && !reset;
    chk("f_req_ready", {31'b0, f_req_ready}, {31'b0, acc_f});
    chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, acc_d});
    chk("mem_read_address", mem_read_address, exp_addr);
    if (reset) begin
      fq.delete();
      dq.delete();
      last_was_f = 0;
    end else if (acc_f) begin
      fq.push_back(expect_word(f_a));
      last_was_f = 1;
    end else if (acc_d) begin
      dq.push_back(expect_word(d_a));
      last_was_f = 0;
    end
    if (acc_f) f_want = 0;
    if (acc_d) d_want = 0;
    @(negedge clk);
  endtask

  task automatic mon_port(input int p, input logic v, input logic [31:0] dat,
                          input logic e, input logic rdy);
    exp_t front;
    bit   exp_v;
    int   sz;
    sz = (p == 0) ? fq.size() : dq.size();
    exp_v = 0;
    if (sz > 0) begin
      front = (p == 0) ? fq[0] : dq[0];
      exp_v = front.cyc < cyc;
    end
    chk(p == 0 ? "f_resp_valid" : "d_resp_valid", {31'b0, v}, {31'b0, exp_v});
    if (exp_v) begin
      chk(p == 0 ? "f_resp_data" : "d_resp_data", dat, front.data);
      chk(p == 0 ? "f_resp_err" : "d_resp_err", {31'b0, e}, {31'b0, front.err});
      if (rdy) begin
        if (p == 0) void'(fq.pop_front());
        else        void'(dq.pop_front());
      end
    end else begin
      chk(p == 0 ? "f_resp_data_idle" : "d_resp_data_idle", dat, 32'h0);
      chk(p == 0 ? "f_resp_err_idle" : "d_resp_err_idle", {31'b0, e}, 32'h0);
    end
  endtask

  // Response monitor, sampled after stimulus has settled for the cycle.
  always begin
    @(negedge clk);
    #2;
    if (started && !reset) begin
      mon_port(0, f_resp_valid, f_resp_data, f_resp_err, f_resp_ready);
      mon_port(1, d_resp_valid, d_resp_data, d_resp_err, d_resp_ready);
    end
  end

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
    if (k == 1) return MEM_SIZE + $urandom_range(0, 64) * 4;
    return $urandom_range(0, 255) * 4;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[2] = 32'h00500093;
    reset = 1'b1;
    f_want = 0; d_want = 0; f_a = 0; d_a = 0;
    f_req_valid = 0; d_req_valid = 0; f_req_addr = 0; d_req_addr = 0;
    f_resp_ready = 0; d_resp_ready = 0;
    @(negedge clk);
    started = 1;
    drive_cycle();
    drive_cycle();
    reset = 1'b0;
    drive_cycle();

    // single fetch
    f_resp_ready = 1; d_resp_ready = 1;
    f_want = 1; f_a = 32'h8;
    drive_cycle();
    drive_cycle();

    // back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      f_want = 1; f_a = i * 4;
      drive_cycle();
    end
    drive_cycle();

    // contention
    for (int i = 0; i < 8; i++) begin
      if (!f_want) begin f_want = 1; f_a = $urandom_range(0, 255) * 4; end
      if (!d_want) begin d_want = 1; d_a = $urandom_range(0, 255) * 4; end
      drive_cycle();
    end
    for (int i = 0; i < 12 && (f_want || d_want); i++) drive_cycle();
    f_want = 0; d_want = 0;
    drive_cycle();

    // error addresses
    f_want = 1; f_a = 32'h6;
    drive_cycle();
    f_want = 1; f_a = 32'h400;
    drive_cycle();
    d_want = 1; d_a = 32'h402;
    drive_cycle();
    drive_cycle();

    // backpressure on fetch with debug waiting
    f_resp_ready = 0;
    f_want = 1; f_a = 32'h10;
    drive_cycle();
    d_want = 1; d_a = 32'h20;
    for (int i = 0; i < 3; i++) drive_cycle();
    f_resp_ready = 1;
    drive_cycle();
    drive_cycle();

    // reset while debug response held
    d_resp_ready = 0;
    d_want = 1; d_a = 32'h30;
    drive_cycle();
    reset = 1;
    drive_cycle();
    reset = 0;
    d_resp_ready = 1;
    drive_cycle();
    f_want = 1; f_a = 32'h8;
    drive_cycle();
    drive_cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!f_want && $urandom_range(0, 3) != 0) begin f_want = 1; f_a = rand_addr(); end
      if (!d_want && $urandom_range(0, 2) == 0) begin d_want = 1; d_a = rand_addr(); end
      f_resp_ready = ($urandom_range(0, 9) < 7);
      d_resp_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 199) == 0);
      if (reset) begin f_want = 0; d_want = 0; end
      drive_cycle();
    end
    reset = 0;
    f_want = 0; d_want = 0;
    f_resp_ready = 1; d_resp_ready = 1;
    drive_cycle();
    drive_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
